// File: rtl/arb_req_frontend_pkg.sv
// rtl/arb_req_frontend_pkg.sv - shared constants for the arbiter request frontend
package arb_req_frontend_pkg;

    localparam int DW_DEFAULT    = 8;
    localparam int DEPTH_DEFAULT = 4;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count; push while full is allowed only alongside a pop
module sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DW-1:0]              din,
    output logic [DW-1:0]              dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop on the same edge frees the slot the push lands in.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/arb_req_frontend.sv
// rtl/arb_req_frontend.sv - two-channel request queues feeding a 2-way arbiter, with grant checking
module arb_req_frontend
    import arb_req_frontend_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_0,
    input  logic          wr_1,
    input  logic [DW-1:0] din_0,
    input  logic [DW-1:0] din_1,
    output logic          full_0,
    output logic          full_1,
    output logic          req_0,
    output logic          req_1,
    input  logic          gnt_0,
    input  logic          gnt_1,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_src,
    output logic          ovf_0,
    output logic          ovf_1,
    output logic          gnt_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [DW-1:0] dout_0;
    logic [DW-1:0] dout_1;
    logic [CW-1:0] count_0;
    logic [CW-1:0] count_1;
    logic          empty_0;
    logic          empty_1;
    logic          dual_gnt;
    logic          pop_0;
    logic          pop_1;

    // A simultaneous double grant is illegal and pops neither channel.
    assign dual_gnt = gnt_0 & gnt_1;
    assign pop_0    = gnt_0 & ~dual_gnt & ~empty_0;
    assign pop_1    = gnt_1 & ~dual_gnt & ~empty_1;

    assign req_0 = ~empty_0;
    assign req_1 = ~empty_1;

    sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo_0 (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_0),
        .pop   (pop_0),
        .din   (din_0),
        .dout  (dout_0),
        .count (count_0),
        .full  (full_0),
        .empty (empty_0)
    );

    sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo_1 (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_1),
        .pop   (pop_1),
        .din   (din_1),
        .dout  (dout_1),
        .count (count_1),
        .full  (full_1),
        .empty (empty_1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= CH0;
            gnt_err   <= 1'b0;
            ovf_0     <= 1'b0;
            ovf_1     <= 1'b0;
        end else begin
            out_valid <= pop_0 | pop_1;
            gnt_err   <= dual_gnt;
            if (pop_0) begin
                out_data <= dout_0;
                out_src  <= CH0;
            end else if (pop_1) begin
                out_data <= dout_1;
                out_src  <= CH1;
            end
            // Sticky: a word dropped on a full queue is recorded until reset.
            if (wr_0 && full_0 && !pop_0) begin
                ovf_0 <= 1'b1;
            end
            if (wr_1 && full_1 && !pop_1) begin
                ovf_1 <= 1'b1;
            end
        end
    end

endmodule
